bit_shift: RTL and testbench
============================

BIT_SHIFT -- requirements
Module: bit_shift

Interface
REQ-001 Parameter ARCHITECTURE, default "BEHAVIORAL", implementation style select: "BEHAVIORAL" or "STRUCTURAL".
REQ-002 Parameter DATA_WIDTH, default 8, word width in bits, legal range 1..256.
REQ-003 Parameter SHIFT_DIRECTION, default 0, 0 = shift left (toward MSB), 1 = shift right (toward LSB).
REQ-004 Parameter NUMBER_BITS, default 1, static shift distance in bits, legal range 0..DATA_WIDTH.
REQ-005 Parameter WRAP, default 0, 0 = logical shift with zero fill, 1 = rotate (bits leaving one end enter the other).
REQ-006 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port rst_n  input  1  asynchronous, active-low reset.
REQ-008 Port data_in  input  DATA_WIDTH  word to be shifted.
REQ-009 Port data_out  output  DATA_WIDTH  registered shifted word.
REQ-010 The block shall have one clock; reset shall be asynchronous and active-low.

Function
REQ-011 data_out shall be driven directly from a DATA_WIDTH-bit register; no combinational path from data_in to data_out.
REQ-012 Latency shall be exactly 1 clk cycle: data_out after rising edge N equals f(data_in sampled at edge N).
REQ-013 A new input shall be accepted every cycle; no handshake, no enable, no stall.
REQ-014 Left, WRAP=0: out[i] = in[i-NUMBER_BITS] for i >= NUMBER_BITS, else 0.
REQ-015 Right, WRAP=0: out[i] = in[i+NUMBER_BITS] for i+NUMBER_BITS < DATA_WIDTH, else 0; no sign extension.
REQ-016 Left, WRAP=1: out[i] = in[(i-NUMBER_BITS) mod DATA_WIDTH].
REQ-017 Right, WRAP=1: out[i] = in[(i+NUMBER_BITS) mod DATA_WIDTH].
REQ-018 NUMBER_BITS=0 shall give a registered pass-through for any direction/WRAP.
REQ-019 NUMBER_BITS=DATA_WIDTH shall give all-zero output when WRAP=0 and pass-through when WRAP=1.
REQ-020 Illegal parameter values (DATA_WIDTH<1, NUMBER_BITS>DATA_WIDTH or <0, SHIFT_DIRECTION or WRAP not 0/1, unknown ARCHITECTURE) shall cause an elaboration-time error.
REQ-021 "BEHAVIORAL" and "STRUCTURAL" shall be cycle- and bit-identical for all legal parameter sets.
REQ-022 "STRUCTURAL" shall build the mapping as a generate loop of per-bit wire selects/constant zeros feeding per-bit flops; "BEHAVIORAL" shall use shift/concatenation operators in one clocked process.

Reset
REQ-023 While rst_n is low, data_out shall be all zeros, asserted immediately without waiting for a clk edge.
REQ-024 On the first rising clk edge after rst_n deasserts, data_out shall load f(data_in); reset deassertion mid-stream shall lose no later sample.

Structure
REQ-025 A shared package bit_shift_pkg shall hold direction constants (SHIFT_LEFT=0, SHIFT_RIGHT=1), wrap constants (WRAP_OFF=0, WRAP_ON=1) and the architecture name strings.
REQ-026 The combinational bit mapping shall live in one sub-module bit_shift_map (parameters as bit_shift, ports data_in/data_shifted, no clock); bit_shift shall add only the output register and the parameter checks.

Verification
REQ-027 DATA_WIDTH=8, left, NUMBER_BITS=1, WRAP=0, data_in=0x55 -> data_out=0xAA one cycle later; 0x80 -> 0x00.
REQ-028 DATA_WIDTH=8, left, NUMBER_BITS=1, WRAP=1, data_in=0x80 -> 0x01; 0x55 -> 0xAA.
REQ-029 DATA_WIDTH=8, right, NUMBER_BITS=3, WRAP=0, data_in=0xFF -> 0x1F; WRAP=1, data_in=0x01 -> 0x20.
REQ-030 rst_n low between clk edges with data_out=0xAA -> data_out=0x00 immediately; held low for 3 edges stays 0x00; first edge after release with data_in=0x55 (left,1,no wrap) -> 0xAA.
REQ-031 Boundaries DATA_WIDTH=16: NUMBER_BITS=0, data_in=0x1234 -> 0x1234; NUMBER_BITS=16, WRAP=0 -> 0x0000; NUMBER_BITS=16, WRAP=1 -> 0x1234.
REQ-032 Random data, every legal direction/WRAP/NUMBER_BITS for DATA_WIDTH in {1,8,13}: BEHAVIORAL and STRUCTURAL instances driven in parallel -> data_out identical every cycle.

Source files
------------

// File: rtl/bit_shift_pkg.sv
// Shared constants for the bit_shift slice: direction, wrap and architecture selectors,
// plus the helper that maps each output bit to the input bit that feeds it.
package bit_shift_pkg;

  localparam int SHIFT_LEFT  = 0;
  localparam int SHIFT_RIGHT = 1;

  localparam int WRAP_OFF = 0;
  localparam int WRAP_ON  = 1;

  localparam ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam ARCH_STRUCTURAL = "STRUCTURAL";

  // Source bit for output bit i, or -1 where a constant zero is shifted in.
  function automatic int src_index(input int i, input int n, input int w,
                                   input int dir, input int wrap);
    int s;
    if (w < 1) return -1;
    s = (dir == SHIFT_LEFT) ? i - n : i + n;
    if (wrap == WRAP_ON) return ((s % w) + w) % w;
    if (s < 0 || s >= w) return -1;
    return s;
  endfunction

endpackage

// File: rtl/bit_shift_map.sv
// Purely combinational static shift/rotate mapping used by bit_shift; no clock.
module bit_shift_map
  import bit_shift_pkg::*;
#(
  parameter     ARCHITECTURE    = "BEHAVIORAL",
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_DIRECTION = 0,
  parameter int NUMBER_BITS     = 1,
  parameter int WRAP            = 0
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_shifted
);

  if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_structural
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      localparam int SRC = src_index(i, NUMBER_BITS, DATA_WIDTH, SHIFT_DIRECTION, WRAP);
      if (SRC < 0) begin : g_zero
        assign data_shifted[i] = 1'b0;
      end else begin : g_sel
        assign data_shifted[i] = data_in[SRC];
      end
    end
  end else begin : g_behavioral
    // Rotation takes the relevant half of the word shifted as a doubled copy of itself.
    logic [2*DATA_WIDTH-1:0] doubled;

    always_comb begin
      doubled      = '0;
      data_shifted = '0;
      if (SHIFT_DIRECTION == SHIFT_LEFT) begin
        doubled      = {data_in, data_in} << NUMBER_BITS;
        data_shifted = (WRAP == WRAP_ON) ? doubled[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                         : data_in << NUMBER_BITS;
      end else begin
        doubled      = {data_in, data_in} >> NUMBER_BITS;
        data_shifted = (WRAP == WRAP_ON) ? doubled[DATA_WIDTH-1:0]
                                         : data_in >> NUMBER_BITS;
      end
    end
  end

endmodule

// File: rtl/bit_shift.sv
// Registered static shift/rotate: one-cycle latency, new word every cycle,
// async active-low reset clears the output immediately.
module bit_shift
  import bit_shift_pkg::*;
#(
  parameter     ARCHITECTURE    = "BEHAVIORAL",
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_DIRECTION = 0,
  parameter int NUMBER_BITS     = 1,
  parameter int WRAP            = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_width
    $error("bit_shift: DATA_WIDTH %0d outside 1..256", DATA_WIDTH);
  end
  if (NUMBER_BITS < 0 || NUMBER_BITS > DATA_WIDTH) begin : g_bad_bits
    $error("bit_shift: NUMBER_BITS %0d outside 0..DATA_WIDTH", NUMBER_BITS);
  end
  if (SHIFT_DIRECTION != SHIFT_LEFT && SHIFT_DIRECTION != SHIFT_RIGHT) begin : g_bad_dir
    $error("bit_shift: SHIFT_DIRECTION %0d must be 0 or 1", SHIFT_DIRECTION);
  end
  if (WRAP != WRAP_OFF && WRAP != WRAP_ON) begin : g_bad_wrap
    $error("bit_shift: WRAP %0d must be 0 or 1", WRAP);
  end
  if (ARCHITECTURE != ARCH_BEHAVIORAL && ARCHITECTURE != ARCH_STRUCTURAL) begin : g_bad_arch
    $error("bit_shift: unknown ARCHITECTURE");
  end

  logic [DATA_WIDTH-1:0] data_shifted;
  logic [DATA_WIDTH-1:0] data_d;

  bit_shift_map #(
    .ARCHITECTURE    (ARCHITECTURE),
    .DATA_WIDTH      (DATA_WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION),
    .NUMBER_BITS     (NUMBER_BITS),
    .WRAP            (WRAP)
  ) u_map (
    .data_in      (data_in),
    .data_shifted (data_shifted)
  );

  always_comb begin
    data_d = data_shifted;
  end

  if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_structural
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      logic bit_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bit_q <= 1'b0;
        else        bit_q <= data_d[i];
      end
      assign data_out[i] = bit_q;
    end
  end else begin : g_behavioral
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end
    assign data_out = data_q;
  end

endmodule

// File: tb/tb_bit_shift.sv
// Bench for bit_shift: directed vectors, async reset behaviour, and random data over every
// legal direction/wrap/distance for widths 1, 8 and 13 in both architectures.
module tb_bit_shift;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  din1;
  logic [7:0]  din8;
  logic [12:0] din13;
  logic [15:0] din16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [0:0]  o1_b  [2][2][2];
  logic [0:0]  o1_s  [2][2][2];
  logic [7:0]  o8_b  [2][2][9];
  logic [7:0]  o8_s  [2][2][9];
  logic [12:0] o13_b [2][2][14];
  logic [12:0] o13_s [2][2][14];
  logic [15:0] o16_n0, o16_full_nowrap, o16_full_wrap;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    for (genvar r = 0; r < 2; r++) begin : g_wrap
      for (genvar n = 0; n <= 1; n++) begin : g_w1
        bit_shift #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(1), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_b (.clk(clk), .rst_n(rst_n), .data_in(din1), .data_out(o1_b[d][r][n]));
        bit_shift #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(1), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_s (.clk(clk), .rst_n(rst_n), .data_in(din1), .data_out(o1_s[d][r][n]));
      end
      for (genvar n = 0; n <= 8; n++) begin : g_w8
        bit_shift #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(8), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_b (.clk(clk), .rst_n(rst_n), .data_in(din8), .data_out(o8_b[d][r][n]));
        bit_shift #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(8), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_s (.clk(clk), .rst_n(rst_n), .data_in(din8), .data_out(o8_s[d][r][n]));
      end
      for (genvar n = 0; n <= 13; n++) begin : g_w13
        bit_shift #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(13), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_b (.clk(clk), .rst_n(rst_n), .data_in(din13), .data_out(o13_b[d][r][n]));
        bit_shift #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(13), .SHIFT_DIRECTION(d),
                    .NUMBER_BITS(n), .WRAP(r))
          u_s (.clk(clk), .rst_n(rst_n), .data_in(din13), .data_out(o13_s[d][r][n]));
      end
    end
  end

  bit_shift #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(16), .SHIFT_DIRECTION(0),
              .NUMBER_BITS(0), .WRAP(0))
    u16_n0 (.clk(clk), .rst_n(rst_n), .data_in(din16), .data_out(o16_n0));
  bit_shift #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(16), .SHIFT_DIRECTION(0),
              .NUMBER_BITS(16), .WRAP(0))
    u16_full_nowrap (.clk(clk), .rst_n(rst_n), .data_in(din16), .data_out(o16_full_nowrap));
  bit_shift #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(16), .SHIFT_DIRECTION(1),
              .NUMBER_BITS(16), .WRAP(1))
    u16_full_wrap (.clk(clk), .rst_n(rst_n), .data_in(din16), .data_out(o16_full_wrap));

  // Reference: word-level arithmetic (multiply/divide by powers of two, OR of the two halves).
  function automatic logic [15:0] model(input longint unsigned d, input int w, input int dir,
                                        input int n, input int wrap);
    longint unsigned mask, res;
    mask = (64'd1 << w) - 64'd1;
    d    = d & mask;
    if (dir == 0) res = (d * (64'd1 << n)) & mask;
    else          res = d / (64'd1 << n);
    if (wrap != 0) begin
      if (dir == 0) res = res | (d / (64'd1 << (w - n)));
      else          res = res | ((d * (64'd1 << (w - n))) & mask);
    end
    return 16'(res & mask);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllRandom();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        for (int n = 0; n <= 1; n++) begin
          checkOutput($sformatf("w1 d%0d r%0d n%0d beh", d, r, n), 16'(o1_b[d][r][n]),
                      model(64'(din1), 1, d, n, r));
          checkOutput($sformatf("w1 d%0d r%0d n%0d str", d, r, n), 16'(o1_s[d][r][n]),
                      model(64'(din1), 1, d, n, r));
        end
        for (int n = 0; n <= 8; n++) begin
          checkOutput($sformatf("w8 d%0d r%0d n%0d beh", d, r, n), 16'(o8_b[d][r][n]),
                      model(64'(din8), 8, d, n, r));
          checkOutput($sformatf("w8 d%0d r%0d n%0d str", d, r, n), 16'(o8_s[d][r][n]),
                      model(64'(din8), 8, d, n, r));
        end
        for (int n = 0; n <= 13; n++) begin
          checkOutput($sformatf("w13 d%0d r%0d n%0d beh", d, r, n), 16'(o13_b[d][r][n]),
                      model(64'(din13), 13, d, n, r));
          checkOutput($sformatf("w13 d%0d r%0d n%0d str", d, r, n), 16'(o13_s[d][r][n]),
                      model(64'(din13), 13, d, n, r));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    din1  = '0;
    din8  = '0;
    din13 = '0;
    din16 = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset w8 left1", 16'(o8_b[0][0][1]), 16'h0000);
    checkOutput("reset w13 rot5 str", 16'(o13_s[1][1][5]), 16'h0000);
    checkOutput("reset w16 full wrap", o16_full_wrap, 16'h0000);
    din8  = 8'h55;
    din16 = 16'h1234;
    applyStimulus();
    checkOutput("reset held w8 left1", 16'(o8_b[0][0][1]), 16'h0000);
    rst_n = 1'b1;

    applyStimulus();
    checkOutput("w8 left1 0x55 beh", 16'(o8_b[0][0][1]), 16'h00AA);
    checkOutput("w8 left1 0x55 str", 16'(o8_s[0][0][1]), 16'h00AA);
    checkOutput("w8 rotl1 0x55", 16'(o8_b[0][1][1]), 16'h00AA);
    checkOutput("w16 n0 pass", o16_n0, 16'h1234);
    checkOutput("w16 n16 nowrap", o16_full_nowrap, 16'h0000);
    checkOutput("w16 n16 wrap", o16_full_wrap, 16'h1234);
    din8 = 8'h80;
    applyStimulus();
    checkOutput("w8 left1 0x80", 16'(o8_b[0][0][1]), 16'h0000);
    checkOutput("w8 rotl1 0x80 str", 16'(o8_s[0][1][1]), 16'h0001);
    din8 = 8'hFF;
    applyStimulus();
    checkOutput("w8 right3 0xFF", 16'(o8_b[1][0][3]), 16'h001F);
    din8 = 8'h01;
    applyStimulus();
    checkOutput("w8 rotr3 0x01 str", 16'(o8_s[1][1][3]), 16'h0020);
    checkOutput("w8 rotr3 0x01 beh", 16'(o8_b[1][1][3]), 16'h0020);

    din8 = 8'h55;
    applyStimulus();
    checkOutput("pre-reset w8 left1", 16'(o8_b[0][0][1]), 16'h00AA);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset immediate", 16'(o8_b[0][0][1]), 16'h0000);
    checkOutput("async reset immediate str", 16'(o8_s[0][0][1]), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput($sformatf("reset hold edge%0d", k), 16'(o8_b[0][0][1]), 16'h0000);
    end
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("first edge after release beh", 16'(o8_b[0][0][1]), 16'h00AA);
    checkOutput("first edge after release str", 16'(o8_s[0][0][1]), 16'h00AA);

    for (int c = 0; c < 200; c++) begin
      din1  = 1'($urandom);
      din8  = 8'($urandom);
      din13 = 13'($urandom);
      applyStimulus();
      checkAllRandom();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
